// File: rtl/instr_fetch_mem.sv
// Instruction memory with a run-time loader port and a decoupled fetch path.
// Accepted fetches return through a 2-entry response FIFO one cycle later.
module instr_fetch_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [ADDR_W:0]   load_count,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              rsp_ready,
  input  logic              flush
);

  localparam int unsigned      DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LOAD_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LOAD_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] fifo_data_q [2];
  logic [ADDR_W-1:0] fifo_addr_q [2];
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              wr_slot;
  logic [ADDR_W:0]   load_count_q, load_count_d;

  logic mem_we;
  logic push;
  logic pop;

  // Writes are dropped while reset is asserted, even though the array itself
  // keeps its contents across reset.
  assign mem_we = reset && load_en && load_we;

  // Acceptance depends only on registered occupancy and load_en, so the core
  // never sees a combinational loop through rsp_ready or flush.
  assign req_ready = reset && !load_en && (count_q < 2'd2);
  assign push      = req_valid && req_ready;
  assign pop       = (count_q != 2'd0) && rsp_ready;

  // A flush rewinds both pointers, so the word accepted alongside it always
  // lands in slot 0 and becomes the new head.
  assign wr_slot = flush ? 1'b0 : wr_ptr_q;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = push;
      count_d  = {1'b0, push};
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    load_count_d = load_count_q;
    if (mem_we && (load_count_q != LOAD_MAX)) begin
      load_count_d = load_count_q + LOAD_ONE;
    end
  end

  // NOTE: the storage array has no reset branch; clearing it would need a
  // reset port on every word and contents are defined only by the loader.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      load_count_q <= '0;
    end else begin
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
    end
  end

  // FIFO slots are cleared on reset so the head reads as zero until the
  // first response arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_addr_q[0] <= '0;
      fifo_addr_q[1] <= '0;
    end else if (push) begin
      fifo_data_q[wr_slot] <= mem_q[req_addr];
      fifo_addr_q[wr_slot] <= req_addr;
    end
  end

  assign rsp_valid  = (count_q != 2'd0);
  assign rsp_data   = fifo_data_q[rd_ptr_q];
  assign rsp_addr   = fifo_addr_q[rd_ptr_q];
  assign load_count = load_count_q;

endmodule
